// File: rtl/fb_scanout_pkg.sv
// fb_scanout_pkg: frame geometry and state types shared by the framebuffer scanout and its helpers.
package fb_scanout_pkg;
  typedef enum logic {IDLE, SCAN} state_t;
  localparam int WORDS_LINE_LO = 4;
  localparam int WORDS_LINE_HI = 8;
  localparam int WORDS_LO      = 128;
  localparam int WORDS_HI      = 512;
  localparam int LAST_LO       = 127;
  localparam int LAST_HI       = 511;
  localparam int LINE_W_LO     = 64;
  localparam int LINE_W_HI     = 128;
  localparam int LINES_LO      = 32;
  localparam int LINES_HI      = 64;
  localparam int X_W           = 7;
  localparam int Y_W           = 6;
  function automatic int last_addr(input logic hires);
    return hires ? LAST_HI : LAST_LO;
  endfunction
endpackage

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: framebuffer read port plus pixel stream; master is the scanout side.
interface fb_scanout_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] buf_addr;
  logic              buf_enable;
  logic              buf_grant;
  logic [WORD_W-1:0] buf_out;
  logic              pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_sol;
  logic              pix_eol;
  modport master (
    output buf_addr, buf_enable, pix_data, pix_valid, pix_sof, pix_sol, pix_eol,
    input  buf_grant, buf_out, pix_ready
  );
  modport slave (
    input  buf_addr, buf_enable, pix_data, pix_valid, pix_sof, pix_sol, pix_eol,
    output buf_grant, buf_out, pix_ready
  );
endinterface

// File: rtl/fb_word_fifo.sv
// fb_word_fifo: 2-entry word FIFO; the head word doubles as the pixel shifter source.
module fb_word_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wp_q, wp_d, rp_q, rp_d, do_push, do_pop;
  logic [1:0]   cnt_q, cnt_d;

  assign full    = cnt_q == 2'd2;
  assign empty   = cnt_q == 2'd0;
  assign count   = cnt_q;
  assign dout    = mem_q[rp_q];
  assign do_push = push & !full;
  assign do_pop  = pop & !empty;

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wp_q] = din;
    wp_d  = wp_q ^ do_push;
    rp_d  = rp_q ^ do_pop;
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: fetches a 1bpp framebuffer word by word and streams it MSB-first as pixels,
// one frame per frame_start, with line/frame markers and valid/ready backpressure.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hires,
  input  logic         frame_start,
  output logic         busy,
  output logic         frame_done,
  fb_scanout_if.master bus
);
  localparam int BW = $clog2(WORD_W);
  localparam logic [BW-1:0] BIT_MAX = BW'(WORD_W - 1);

  state_t            state_q, state_d;
  logic              hires_q, hires_d, pend_q, done_q;
  logic [ADDR_W:0]   fetch_q, fetch_d, last_w;
  logic [BW-1:0]     bit_q, bit_d;
  logic [X_W-1:0]    x_q, x_d, x_max;
  logic [Y_W-1:0]    y_q, y_d, y_max;
  logic [WORD_W-1:0] head;
  logic [1:0]        count;
  logic              full, empty, scan, fetch, valid, xfer, pop, last_px;

  assign scan    = state_q == SCAN;
  assign last_w  = (ADDR_W + 1)'(last_addr(hires_q));
  assign x_max   = hires_q ? X_W'(LINE_W_HI - 1) : X_W'(LINE_W_LO - 1);
  assign y_max   = hires_q ? Y_W'(LINES_HI - 1) : Y_W'(LINES_LO - 1);
  // A read in flight already owns a FIFO slot, so its capture can never overflow.
  assign fetch   = scan & bus.buf_grant & (fetch_q <= last_w) & !full
                 & ((3'(count) + 3'(pend_q)) < 3'd2);
  assign valid   = scan & !empty;
  assign xfer    = valid & bus.pix_ready;
  assign pop     = xfer & (bit_q == '0);
  assign last_px = xfer & (x_q == x_max) & (y_q == y_max);

  assign bus.buf_enable = fetch;
  assign bus.buf_addr   = fetch_q[ADDR_W-1:0];
  assign bus.pix_valid  = valid;
  assign bus.pix_data   = valid & head[bit_q];
  assign bus.pix_sol    = valid & (x_q == '0);
  assign bus.pix_eol    = valid & (x_q == x_max);
  assign bus.pix_sof    = valid & (x_q == '0) & (y_q == '0);
  assign busy           = scan;
  assign frame_done     = done_q;

  fb_word_fifo #(.W(WORD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pend_q),
    .pop   (pop),
    .din   (bus.buf_out),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_d = state_q;
    hires_d = hires_q;
    fetch_d = fetch_q + (ADDR_W + 1)'(fetch);
    bit_d   = xfer ? ((bit_q == '0) ? BIT_MAX : bit_q - BW'(1)) : bit_q;
    x_d     = xfer ? ((x_q == x_max) ? '0 : x_q + X_W'(1)) : x_q;
    y_d     = (xfer & (x_q == x_max)) ? y_q + Y_W'(1) : y_q;
    if (!scan && frame_start) begin
      state_d = SCAN;
      hires_d = hires;
      fetch_d = '0;
      bit_d   = BIT_MAX;
      x_d     = '0;
      y_d     = '0;
    end
    if (last_px) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hires_q <= 1'b0;
      fetch_q <= '0;
      pend_q  <= 1'b0;
      bit_q   <= BIT_MAX;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hires_q <= hires_d;
      fetch_q <= fetch_d;
      pend_q  <= fetch;
      bit_q   <= bit_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= last_px;
    end
  end
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: scoreboard bench; expected pixels are queued at frame_start from the memory image.
module tb_fb_scanout;
  localparam int WW = 16;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic hires = 1'b0;
  logic frame_start = 1'b0;
  logic busy, frame_done;

  fb_scanout_if #(.WORD_W(WW), .ADDR_W(AW)) bus ();

  fb_scanout #(.WORD_W(WW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hires       (hires),
    .frame_start (frame_start),
    .busy        (busy),
    .frame_done  (frame_done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [512];
  always @(posedge clk) if (bus.buf_enable) bus.buf_out <= mem[bus.buf_addr];

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];

  int st_xfers, st_eol, st_sol, st_done, st_bubbles, st_en_gap, st_fetch_bad, st_fetch_n;
  int st_last_addr, st_first_valid, st_last_xfer_cyc, st_done_cyc, st_busy_at_done, st_first_sof;

  task automatic push_frame(input logic h);
    int w = h ? 128 : 64;
    int n = h ? 8192 : 2048;
    for (int i = 0; i < n; i++) begin
      logic [WW-1:0] wd = mem[i / 16];
      exp_q.push_back({wd[15 - (i % 16)], i == 0, (i % w) == 0, (i % w) == w - 1});
    end
  endtask

  task automatic scan_frame(input logic h, input bit rnd_ready, input int gap_at, input int gap_len,
                            input int toggle_at, input int restart_at, input int abort_at, input int tail);
    logic [4:0] prev = '0;
    logic [3:0] got, exp;
    bit stalled = 0;
    int cyc;
    int fetch_exp = 0;
    st_xfers = 0; st_eol = 0; st_sol = 0; st_done = 0; st_bubbles = 0; st_en_gap = 0;
    st_fetch_bad = 0; st_last_addr = -1; st_first_valid = -1; st_last_xfer_cyc = -1;
    st_done_cyc = -1; st_busy_at_done = -1; st_first_sof = -1;
    @(negedge clk);
    frame_start = 1'b1;
    hires = h;
    bus.buf_grant = 1'b1;
    bus.pix_ready = 1'b1;
    push_frame(h);
    for (cyc = 1; cyc < 30000; cyc++) begin
      @(negedge clk);
      frame_start = (cyc == restart_at);
      if (cyc == toggle_at) hires = ~hires;
      bus.buf_grant = !(cyc >= gap_at && cyc < gap_at + gap_len);
      bus.pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.buf_enable) begin
        if (!bus.buf_grant) st_en_gap++;
        if (int'(bus.buf_addr) != fetch_exp) st_fetch_bad++;
        fetch_exp++;
        st_last_addr = int'(bus.buf_addr);
      end
      if (stalled) begin
        checks++;
        if ({bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_sol, bus.pix_eol} !== prev) begin
          errors++;
          $display("FAIL stall_hold cyc %0d: got %b want %b", cyc,
                   {bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_sol, bus.pix_eol}, prev);
        end
      end
      if (bus.pix_valid && st_first_valid < 0) st_first_valid = cyc - 1;
      if (st_first_valid >= 0 && !bus.pix_valid && busy) st_bubbles++;
      if (bus.pix_valid && bus.pix_ready) begin
        got = {bus.pix_data, bus.pix_sof, bus.pix_sol, bus.pix_eol};
        if (st_xfers == 0) st_first_sof = int'(bus.pix_sof);
        st_xfers++;
        st_eol += int'(bus.pix_eol);
        st_sol += int'(bus.pix_sol);
        st_last_xfer_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pixel_extra %0d: got %b want none", st_xfers - 1, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL pixel %0d: got %b want %b (data,sof,sol,eol)", st_xfers - 1, got, exp);
          end
        end
      end
      stalled = bus.pix_valid && !bus.pix_ready;
      prev = {bus.pix_valid, bus.pix_data, bus.pix_sof, bus.pix_sol, bus.pix_eol};
      if (frame_done) begin
        st_done++;
        if (st_done == 1) begin
          st_done_cyc = cyc;
          st_busy_at_done = int'(busy);
        end
      end
      if (abort_at >= 0 && st_xfers == abort_at) break;
      if (st_done > 0 && cyc - st_done_cyc >= tail) break;
    end
    st_fetch_n = fetch_exp;
    checks++;
    if (cyc >= 30000) begin
      errors++;
      $display("FAIL timeout: got %0d xfers, frame never ended", st_xfers);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, frame_done, bus.pix_valid, bus.buf_enable, bus.pix_data, bus.pix_sof, bus.pix_sol,
         bus.pix_eol, bus.buf_addr} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got nonzero, want all 0");
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, bus.pix_valid, bus.buf_enable} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 000", {busy, bus.pix_valid, bus.buf_enable});
    end
  endtask

  task automatic test_lores();
    scan_frame(1'b0, 0, -1, 0, -1, -1, -1, 3);
    checks++; if (st_xfers !== 2048) begin errors++; $display("FAIL lores_xfers: got %0d want 2048", st_xfers); end
    checks++; if (st_eol !== 32) begin errors++; $display("FAIL lores_eol: got %0d want 32", st_eol); end
    checks++; if (st_done !== 1) begin errors++; $display("FAIL lores_done: got %0d want 1", st_done); end
    checks++; if (st_first_valid !== 2) begin errors++; $display("FAIL latency: got %0d want 2", st_first_valid); end
    checks++; if (st_bubbles !== 0) begin errors++; $display("FAIL lores_bubbles: got %0d want 0", st_bubbles); end
    checks++; if (st_done_cyc !== st_last_xfer_cyc + 1) begin errors++; $display("FAIL done_timing: got %0d want %0d", st_done_cyc, st_last_xfer_cyc + 1); end
    checks++; if (st_busy_at_done !== 0) begin errors++; $display("FAIL busy_at_done: got %0d want 0", st_busy_at_done); end
    checks++; if (st_fetch_n !== 128 || st_fetch_bad !== 0) begin errors++; $display("FAIL lores_fetch: got %0d fetches %0d bad, want 128/0", st_fetch_n, st_fetch_bad); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL lores_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_hires();
    scan_frame(1'b1, 0, -1, 0, 500, -1, -1, 2);
    checks++; if (st_xfers !== 8192) begin errors++; $display("FAIL hires_xfers: got %0d want 8192", st_xfers); end
    checks++; if (st_sol !== 64) begin errors++; $display("FAIL hires_sol: got %0d want 64", st_sol); end
    checks++; if (st_last_addr !== 511) begin errors++; $display("FAIL hires_last_addr: got %0d want 511", st_last_addr); end
    checks++; if (st_fetch_n !== 512 || st_fetch_bad !== 0) begin errors++; $display("FAIL hires_fetch: got %0d fetches %0d bad, want 512/0", st_fetch_n, st_fetch_bad); end
    checks++; if (st_done !== 1) begin errors++; $display("FAIL hires_done: got %0d want 1", st_done); end
  endtask

  task automatic test_random_ready();
    scan_frame(1'b0, 1, -1, 0, -1, -1, -1, 2);
    checks++; if (st_xfers !== 2048) begin errors++; $display("FAIL rnd_xfers: got %0d want 2048", st_xfers); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rnd_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_grant_gap();
    scan_frame(1'b0, 0, 300, 20, -1, -1, -1, 2);
    checks++; if (st_en_gap !== 0) begin errors++; $display("FAIL gap20_enable: got %0d want 0", st_en_gap); end
    checks++; if (st_fetch_n !== 128 || st_fetch_bad !== 0) begin errors++; $display("FAIL gap20_fetch: got %0d fetches %0d bad, want 128/0", st_fetch_n, st_fetch_bad); end
    checks++; if (exp_q.size() !== 0 || st_xfers !== 2048) begin errors++; $display("FAIL gap20_pixels: got %0d xfers want 2048", st_xfers); end
    scan_frame(1'b0, 0, 300, 40, -1, -1, -1, 2);
    checks++; if (st_en_gap !== 0) begin errors++; $display("FAIL gap40_enable: got %0d want 0", st_en_gap); end
    checks++; if (st_bubbles < 8) begin errors++; $display("FAIL gap40_drain: got %0d bubbles want >=8", st_bubbles); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL gap40_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_restart_abort();
    int bad = 0;
    scan_frame(1'b0, 0, -1, 0, -1, 200, 1000, 0);
    checks++; if (st_done !== 0 || st_xfers !== 1000) begin errors++; $display("FAIL restart_ignored: got %0d xfers %0d done want 1000/0", st_xfers, st_done); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, bus.pix_valid, bus.buf_enable, bus.pix_data, bus.pix_sof, bus.pix_sol,
         bus.pix_eol, bus.buf_addr} !== 17'd0) begin
      errors++;
      $display("FAIL abort_outputs: got nonzero, want all 0 immediately");
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (bus.pix_valid || frame_done || bus.buf_enable || busy) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int first_xfers;
    scan_frame(1'b0, 0, -1, 0, -1, -1, -1, 0);
    first_xfers = st_xfers;
    checks++; if (first_xfers !== 2048 || st_done !== 1) begin errors++; $display("FAIL b2b_first: got %0d xfers %0d done want 2048/1", first_xfers, st_done); end
    scan_frame(1'b0, 0, -1, 0, -1, -1, -1, 2);
    checks++; if (st_first_sof !== 1) begin errors++; $display("FAIL b2b_sof: got %0d want 1", st_first_sof); end
    checks++; if (st_xfers !== 2048 || st_done !== 1) begin errors++; $display("FAIL b2b_second: got %0d xfers %0d done want 2048/1", st_xfers, st_done); end
  endtask

  initial begin
    bus.buf_grant = 1'b1;
    bus.pix_ready = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = WW'($urandom);
    mem[0] = 16'h8001;
    test_reset();
    test_lores();
    test_hires();
    test_random_ready();
    test_grant_gap();
    test_restart_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
